// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder driving one full-adder cell LSB first, valid/ready in and out
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready, a, b, cin : operand handshake
//   out_valid/out_ready, sum, cout : result handshake, registered outputs
module adder (
  input  logic in1,
  input  logic in2,
  input  logic carryin,
  output logic out,
  output logic carryout
);
  assign out      = in1 ^ in2 ^ carryin;
  assign carryout = (in1 & in2) | (carryin & (in1 ^ in2));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] opa, opb, sum_r;
  logic [CW-1:0] cnt;
  logic carry, s, co, last;
  adder u_adder (
    .in1     (opa[0]),
    .in2     (opb[0]),
    .carryin (carry),
    .out     (s),
    .carryout(co)
  );
  assign last      = cnt == CW'(WIDTH - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sum       = sum_r;
  assign cout      = carry;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // Concatenate-then-shift keeps the MSB insertion legal for WIDTH = 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      sum_r <= WIDTH'({s, sum_r} >> 1);
      carry <= co;
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's one-bit full-adder cell (module `adder`). The cell is instantiated exactly once.
- Operands are captured on a valid/ready handshake and presented to the cell LSB first, one bit per clock.
- The cell's carry-out is registered and fed back as the next bit's carry-in.
- The sum is collected in a shift register and released on a valid/ready output handshake. This is the sequential upstream driver for the full-adder cell, trading latency for area.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  initial carry-in
out_valid  output  1  sum and cout are valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. rst is sampled on the rising edge of clk and has priority over all other inputs.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - sum = 0, cout = 0.
  - Operand shift registers = 0, carry register = 0, bit counter = 0.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1: capture a and b into shift registers, load the carry register with cin, clear the counter, go to SHIFT.
- SHIFT:
  - in_ready = 0, out_valid = 0.
  - Each edge: drive the cell with in1 = opA[0], in2 = opB[0], carryin = carry register.
  - On that edge:
    - Shift opA and opB right by 1.
    - Shift the sum register right by 1, inserting the cell's out at the MSB.
    - Load the carry register with the cell's carryout.
    - Increment the counter.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th shift): go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - sum = sum register; cout = carry register.
  - Both are held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE. There is no same-cycle bypass into a new transaction.
- Latency and throughput:
  - Operands are accepted at edge E0.
  - out_valid is high after edge E0+WIDTH.
  - Minimum spacing between accepted transactions is WIDTH+2 cycles.
- Inputs outside IDLE:
  - in_valid is ignored in SHIFT and DONE.
  - Changes on a, b or cin after acceptance have no effect.
- out_ready is ignored outside DONE.
- Widths:
  - Counter width is clog2(WIDTH), minimum 1 bit.
  - Sum is modulo 2^WIDTH; overflow is reported only on cout.
- WIDTH = 1 must work: one SHIFT cycle, then DONE.
- Reset mid-operation (SHIFT or DONE):
  - Abandon the operation and return to reset values on that edge. No partial result is presented.
  - in_ready = 1 on the following cycle.
- sum and cout outputs are registered. No combinational path exists from any input to any output except through state.

Test Plan:
- WIDTH=8; a=0x3C, b=0x5A, cin=0, accepted at E0 -> out_valid rises after E8; sum=0x96, cout=0; in_ready=0 during E1..E8.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: result ready with out_ready held 0 for 5 cycles -> sum, cout and out_valid constant; in_ready=0 and in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Input changes after accept: a=0x10, b=0x20 accepted, then a and b changed to 0xFF during SHIFT -> sum=0x30, cout=0.
- Reset mid-operation: rst=1 at the 4th SHIFT edge -> next cycle out_valid=0, in_ready=1, sum=0, cout=0. Then a=0x01, b=0x02, cin=0 -> sum=0x03, cout=0.
- WIDTH=1 instance: a=1, b=1, cin=1 -> out_valid after E1, sum=1, cout=1. Random regression over 1000 operand pairs compared against a+b+cin.
